// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the serial subtractor.
// Both channels are valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its payload
// stable from raising valid until that edge.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_diff;
   logic             out_bout;
   logic             out_ovf;
   // FSM state of the subtractor, observable for checkers (0 idle, 1 busy, 2 done)
   logic [1:0]       dbg_state;

   modport master (
      output in_valid, in_a, in_b, in_bin, out_ready,
      input  in_ready, out_valid, out_diff, out_bout, out_ovf, dbg_state
   );

   modport slave (
      input  in_valid, in_a, in_b, in_bin, out_ready,
      output in_ready, out_valid, out_diff, out_bout, out_ovf, dbg_state
   );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: a - b - bin over WIDTH bits, BITS_PER_CYCLE bits
// per clock, LSB chunk first, through one chunk-wide a + ~b + carry chain.
module serial_subtractor #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   serial_subtractor_if.slave bus
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int SW = (N > 1) ? $clog2(N) : 1;
   localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

   if ((WIDTH < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 1 and a multiple of BITS_PER_CYCLE");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic                      w_in_ready;
   logic                      w_out_valid;
   logic                      w_accept;
   logic                      w_last;

   logic [WIDTH-1:0]          r_a;
   logic [WIDTH-1:0]          r_b;
   logic [WIDTH-1:0]          r_res;
   logic                      r_carry;
   logic [SW-1:0]             r_step;
   logic [WIDTH-1:0]          r_diff;
   logic                      r_bout;
   logic                      r_ovf;

   logic [BITS_PER_CYCLE-1:0] w_a_chunk;
   logic [BITS_PER_CYCLE-1:0] w_b_chunk;
   logic [BITS_PER_CYCLE:0]   w_sum;
   logic [WIDTH-1:0]          w_res_next;

   assign w_accept = (r_state == S_IDLE) && bus.in_valid;
   assign w_last   = (r_step == LAST_STEP);

   // State register; reset aborts any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state; ready/valid are pure state decodes so no input reaches them combinationally
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_next = S_BUSY;
         end
         S_BUSY: begin
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // One chunk of a + ~b + carry; the chunk lands in its slot of the result register
   always_comb begin
      w_a_chunk  = r_a[int'(r_step) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
      w_b_chunk  = r_b[int'(r_step) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
      w_sum      = {1'b0, w_a_chunk} + {1'b0, ~w_b_chunk} + {{BITS_PER_CYCLE{1'b0}}, r_carry};
      w_res_next = r_res;
      w_res_next[int'(r_step) * BITS_PER_CYCLE +: BITS_PER_CYCLE] = w_sum[BITS_PER_CYCLE-1:0];
   end

   // Operand capture, chunk iteration and result publication on the final chunk
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_step  <= '0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= bus.in_a;
         r_b     <= bus.in_b;
         r_carry <= ~bus.in_bin;
         r_step  <= '0;
         r_res   <= '0;
      end else if (r_state == S_BUSY) begin
         r_res   <= w_res_next;
         r_carry <= w_sum[BITS_PER_CYCLE];
         if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= ~w_sum[BITS_PER_CYCLE];
            r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
         end else begin
            r_step <= r_step + 1'b1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_diff  = r_diff;
   assign bus.out_bout  = r_bout;
   assign bus.out_ovf   = r_ovf;
   assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: four instances (BITS_PER_CYCLE 1, 2, 4, 8 at
// WIDTH 8) share one stimulus stream; each has its own expected queue.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_bin;
   logic       out_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;

   logic [3:0] w_ir;
   logic [3:0] w_ov;
   logic [3:0] w_bout;
   logic [3:0] w_ovf;
   logic [7:0] w_diff [4];
   logic [1:0] w_st   [4];

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q [4][$];

   // clock
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      serial_subtractor_if #(.WIDTH(8)) u_if ();

      assign u_if.in_valid  = in_valid;
      assign u_if.in_a      = in_a;
      assign u_if.in_b      = in_b;
      assign u_if.in_bin    = in_bin;
      assign u_if.out_ready = out_ready;

      assign w_ir[g]   = u_if.in_ready;
      assign w_ov[g]   = u_if.out_valid;
      assign w_diff[g] = u_if.out_diff;
      assign w_bout[g] = u_if.out_bout;
      assign w_ovf[g]  = u_if.out_ovf;
      assign w_st[g]   = u_if.dbg_state;

      serial_subtractor #(
         .WIDTH          (8),
         .BITS_PER_CYCLE (1 << g)
      ) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (u_if.slave)
      );
   end

   // reference: {ovf, bout, diff}
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      logic [8:0] full;
      logic [7:0] d;
      full = {1'b0, a} - {1'b0, b} - {8'd0, bin};
      d    = full[7:0];
      return {(a[7] != b[7]) && (d[7] != a[7]), full[8], d};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // one clock: scoreboard at the falling edge, then return just after the rising edge
   task automatic tick();
      logic [9:0] e;
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
         if (rst) begin
            exp_q[d].delete();
         end else begin
            if (in_valid && w_ir[d]) exp_q[d].push_back(model(in_a, in_b, in_bin));
            if (w_ov[d] && out_ready) begin
               if (exp_q[d].size() == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL unexpected_result bpc%0d observed=%0h expected=none", 1 << d,
                         {w_ovf[d], w_bout[d], w_diff[d]});
               end else begin
                  e = exp_q[d].pop_front();
                  check($sformatf("result_bpc%0d", 1 << d),
                        32'({w_ovf[d], w_bout[d], w_diff[d]}), 32'(e));
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input bit rnd);
      int n;
      n = 0;
      while (w_ir != 4'hF && n < 64) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
      end
      out_ready = 1'b1;
      if (w_ir != 4'hF) begin
         checks++;
         errors++;
         $error("FAIL idle_timeout observed=%b expected=1111", w_ir);
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit rnd);
      wait_idle(1'b0);
      in_a     = a;
      in_b     = b;
      in_bin   = bin;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_idle(rnd);
   endtask

   initial begin
      int         lat [4];
      logic [9:0] rec [4];
      int         n;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_bin    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // reset state
      check("rst_in_ready", 32'(w_ir), 32'hF);
      check("rst_out_valid", 32'(w_ov), 32'h0);
      check("rst_bout", 32'(w_bout), 32'h0);
      check("rst_ovf", 32'(w_ovf), 32'h0);
      for (int d = 0; d < 4; d++) begin
         check("rst_diff", 32'(w_diff[d]), 32'h0);
         check("rst_state", 32'(w_st[d]), 32'h0);
      end
      rst = 1'b0;
      tick();

      // 5 - 3 with latency per instance and in_ready low while busy
      in_a     = 8'h05;
      in_b     = 8'h03;
      in_bin   = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int d = 0; d < 4; d++) lat[d] = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         for (int d = 0; d < 4; d++) if (lat[d] == 0 && w_ov[d]) lat[d] = k;
         if (k < 8) begin
            check("busy_in_ready", 32'(w_ir[0]), 32'h0);
            check("busy_state", 32'(w_st[0]), 32'h1);
         end
      end
      for (int d = 0; d < 4; d++) check($sformatf("latency_bpc%0d", 1 << d), 32'(lat[d]), 32'(8 >> d));
      wait_idle(1'b0);

      // directed vectors and boundaries
      run_op(8'h03, 8'h05, 1'b0, 1'b0);
      run_op(8'h80, 8'h01, 1'b0, 1'b0);
      run_op(8'h00, 8'h00, 1'b1, 1'b0);
      run_op(8'hA5, 8'hA5, 1'b0, 1'b0);
      run_op(8'h34, 8'h12, 1'b0, 1'b0);
      run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
      run_op(8'hFF, 8'h00, 1'b1, 1'b0);
      run_op(8'h00, 8'hFF, 1'b1, 1'b0);

      // backpressure: results held in DONE, inputs ignored
      out_ready = 1'b0;
      in_a      = 8'h5A;
      in_b      = 8'h3C;
      in_bin    = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (w_ov != 4'hF && n < 20) begin
         tick();
         n++;
      end
      check("bp_all_done", 32'(w_ov), 32'hF);
      for (int d = 0; d < 4; d++) rec[d] = {w_ovf[d], w_bout[d], w_diff[d]};
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_a     = 8'($urandom);
         in_b     = 8'($urandom);
         in_bin   = 1'($urandom_range(0, 1));
         tick();
         check("bp_out_valid", 32'(w_ov), 32'hF);
         check("bp_in_ready", 32'(w_ir), 32'h0);
         for (int d = 0; d < 4; d++) check("bp_hold", 32'({w_ovf[d], w_bout[d], w_diff[d]}), 32'(rec[d]));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", 32'(w_ir), 32'hF);
      check("bp_release_out_valid", 32'(w_ov), 32'h0);
      for (int d = 0; d < 4; d++) check("bp_retain", 32'({w_ovf[d], w_bout[d], w_diff[d]}), 32'(rec[d]));
      run_op(8'h21, 8'h11, 1'b0, 1'b0);

      // reset in the middle of the bit-serial instance's operation
      in_a     = 8'hC3;
      in_b     = 8'h4D;
      in_bin   = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      check("pre_abort_state", 32'(w_st[0]), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("abort_out_valid", 32'(w_ov), 32'h0);
      check("abort_in_ready", 32'(w_ir), 32'hF);
      for (int d = 0; d < 4; d++) begin
         check("abort_diff", 32'(w_diff[d]), 32'h0);
         check("abort_state", 32'(w_st[d]), 32'h0);
      end
      tick();
      rst = 1'b0;
      tick();
      run_op(8'h10, 8'h01, 1'b0, 1'b0);

      // random sweep with random output backpressure
      for (int i = 0; i < 1000; i++) begin
         run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      end

      for (int d = 0; d < 4; d++) check($sformatf("queue_empty_bpc%0d", 1 << d), 32'(exp_q[d].size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
